// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage RV32IM pipeline: EX forwarding, load-use stalls,
// a scoreboard of registers pending on the multi-cycle MDU, and event counters.
module hazard_scoreboard #(
  parameter int unsigned RAW       = 5,
  parameter int unsigned MDU_DEPTH = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RAW-1:0]      raddr1D,
  input  logic [RAW-1:0]      raddr2D,
  input  logic                rs1_usedD,
  input  logic                rs2_usedD,
  input  logic [RAW-1:0]      waddrD,
  input  logic                reg_wrD,
  input  logic                mdu_opD,
  input  logic [RAW-1:0]      raddr1E,
  input  logic [RAW-1:0]      raddr2E,
  input  logic [RAW-1:0]      waddrE,
  input  logic                mem_rdE,
  input  logic                mdu_startE,
  input  logic [RAW-1:0]      waddrM,
  input  logic                reg_wrM,
  input  logic [RAW-1:0]      waddrW,
  input  logic                reg_wrW,
  input  logic                mdu_doneW,
  input  logic                br_taken,
  input  logic                cnt_clr,
  output logic                StallF,
  output logic                StallD,
  output logic                FlushD,
  output logic                FlushE,
  output logic [1:0]          forwardAE,
  output logic [1:0]          forwardBE,
  output logic [2**RAW-1:0]   busy_vec,
  output logic [2:0]          mdu_cnt,
  output logic                sb_err,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  localparam int unsigned NREGS  = 2**RAW;
  localparam logic [2:0]  DepthC = 3'(MDU_DEPTH);
  localparam logic [3:0]  DepthW = 4'(MDU_DEPTH);
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NREGS-1:0] busy_q, busy_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic start_v, rs1_v, rs2_v;
  logic raw_hit, lu_hit, waw_hit, full_hit, stall;
  logic [3:0] cnt_sum;
  logic inc, dec;

  // M result has priority over W; x0 is never forwarded.
  always_comb begin
    forwardAE = 2'b01;
    forwardBE = 2'b01;
    if (raddr1E != '0 && reg_wrM && raddr1E == waddrM)      forwardAE = 2'b00;
    else if (raddr1E != '0 && reg_wrW && raddr1E == waddrW) forwardAE = 2'b10;
    if (raddr2E != '0 && reg_wrM && raddr2E == waddrM)      forwardBE = 2'b00;
    else if (raddr2E != '0 && reg_wrW && raddr2E == waddrW) forwardBE = 2'b10;
  end

  always_comb begin
    start_v  = mdu_startE && (waddrE != '0);
    rs1_v    = rs1_usedD && (raddr1D != '0);
    rs2_v    = rs2_usedD && (raddr2D != '0);
    raw_hit  = (rs1_v && (busy_q[raddr1D] || (start_v && raddr1D == waddrE)))
            || (rs2_v && (busy_q[raddr2D] || (start_v && raddr2D == waddrE)));
    lu_hit   = mem_rdE && ((rs1_v && raddr1D == waddrE) || (rs2_v && raddr2D == waddrE));
    waw_hit  = reg_wrD && (waddrD != '0)
            && (busy_q[waddrD] || (start_v && waddrD == waddrE));
    cnt_sum  = {1'b0, cnt_q} + {3'b000, mdu_startE};
    full_hit = mdu_opD && (cnt_sum >= DepthW);
    stall    = raw_hit || lu_hit || waw_hit || full_hit;

    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (br_taken) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (mdu_doneW) busy_d[waddrW] = 1'b0;
    // Set applied after clear so a same-index set wins.
    if (start_v)   busy_d[waddrE] = 1'b1;
    busy_d[0] = 1'b0;

    inc   = mdu_startE && (cnt_q != DepthC);
    dec   = mdu_doneW && (cnt_q != 3'd0);
    cnt_d = cnt_q + {2'b00, inc} - {2'b00, dec};

    err_d = err_q
         || (mdu_doneW && ((cnt_q == 3'd0) || !busy_q[waddrW]))
         || (mdu_startE && (cnt_q == DepthC));

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (StallF && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CntOne;
      if (br_taken && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign busy_vec  = busy_q;
  assign mdu_cnt   = cnt_q;
  assign sb_err    = err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: expected outputs are queued as
// stimulus is driven and compared when the DUT presents them.
module tb_hazard_scoreboard;

  localparam int unsigned RAW = 5;
  localparam int unsigned NREGS = 32;
  localparam int unsigned CNT_W = 16;

  logic clk, rst;
  logic [RAW-1:0] raddr1D, raddr2D, waddrD, raddr1E, raddr2E, waddrE, waddrM, waddrW;
  logic rs1_usedD, rs2_usedD, reg_wrD, mdu_opD, mem_rdE, mdu_startE;
  logic reg_wrM, reg_wrW, mdu_doneW, br_taken, cnt_clr;
  logic StallF, StallD, FlushD, FlushE;
  logic [1:0] forwardAE, forwardBE;
  logic [NREGS-1:0] busy_vec;
  logic [2:0] mdu_cnt;
  logic sb_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_scoreboard #(.RAW(5), .MDU_DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .raddr1D(raddr1D), .raddr2D(raddr2D), .rs1_usedD(rs1_usedD), .rs2_usedD(rs2_usedD),
    .waddrD(waddrD), .reg_wrD(reg_wrD), .mdu_opD(mdu_opD),
    .raddr1E(raddr1E), .raddr2E(raddr2E), .waddrE(waddrE), .mem_rdE(mem_rdE),
    .mdu_startE(mdu_startE), .waddrM(waddrM), .reg_wrM(reg_wrM),
    .waddrW(waddrW), .reg_wrW(reg_wrW), .mdu_doneW(mdu_doneW),
    .br_taken(br_taken), .cnt_clr(cnt_clr),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .busy_vec(busy_vec),
    .mdu_cnt(mdu_cnt), .sb_err(sb_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic [3:0] ctl;  // {StallF, StallD, FlushD, FlushE}
    logic [1:0] fa;
    logic [1:0] fb;
  } comb_t;

  typedef struct packed {
    logic [31:0] busy;
    logic [2:0]  cnt;
    logic        err;
    logic [15:0] sc;
    logic [15:0] fc;
  } st_t;

  comb_t cq[$];
  st_t   sq[$];
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_sc = '0;
  logic [15:0] exp_fc = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    raddr1D = '0; raddr2D = '0; waddrD = '0; raddr1E = '0; raddr2E = '0;
    waddrE = '0; waddrM = '0; waddrW = '0;
    rs1_usedD = 0; rs2_usedD = 0; reg_wrD = 0; mdu_opD = 0; mem_rdE = 0;
    mdu_startE = 0; reg_wrM = 0; reg_wrW = 0; mdu_doneW = 0; br_taken = 0; cnt_clr = 0;
  endtask

  // Caller sets inputs at a negedge; step queues the combinational and
  // post-edge expectations, compares each as the DUT produces it.
  task automatic step(input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [31:0] busy, input logic [2:0] cnt, input logic e);
    comb_t c;
    st_t s;
    c.ctl = ctl; c.fa = fa; c.fb = fb;
    cq.push_back(c);
    if (cnt_clr) begin
      exp_sc = '0;
      exp_fc = '0;
    end else begin
      if (ctl[3] && exp_sc != '1) exp_sc = exp_sc + 16'd1;
      if (br_taken && exp_fc != '1) exp_fc = exp_fc + 16'd1;
    end
    s.busy = busy; s.cnt = cnt; s.err = e; s.sc = exp_sc; s.fc = exp_fc;
    sq.push_back(s);
    #1;
    c = cq.pop_front();
    chk("ctl", 64'({StallF, StallD, FlushD, FlushE}), 64'(c.ctl));
    chk("fwdA", 64'(forwardAE), 64'(c.fa));
    chk("fwdB", 64'(forwardBE), 64'(c.fb));
    @(negedge clk);
    s = sq.pop_front();
    chk("busy", 64'(busy_vec), 64'(s.busy));
    chk("cnt", 64'(mdu_cnt), 64'(s.cnt));
    chk("err", 64'(sb_err), 64'(s.err));
    chk("stall_cnt", 64'(stall_cnt), 64'(s.sc));
    chk("flush_cnt", 64'(flush_cnt), 64'(s.fc));
    idle();
  endtask

  localparam logic [3:0] NoSt = 4'b0000;
  localparam logic [3:0] St   = 4'b1101;
  localparam logic [3:0] Br   = 4'b0011;
  localparam logic [31:0] B3  = 32'h1 << 3;
  localparam logic [31:0] B4  = 32'h1 << 4;

  initial begin
    idle();
    rst = 1'b1;
    #1;
    chk("rst_busy", 64'(busy_vec), 64'd0);
    chk("rst_cnt", 64'(mdu_cnt), 64'd0);
    chk("rst_err", 64'(sb_err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Forwarding
    raddr1E = 5; raddr2E = 5; waddrM = 5; reg_wrM = 1; waddrW = 5; reg_wrW = 1;
    step(NoSt, 2'b00, 2'b00, 0, 0, 0);
    raddr1E = 5; raddr2E = 6; waddrW = 5; reg_wrW = 1;
    step(NoSt, 2'b10, 2'b01, 0, 0, 0);
    raddr1E = 0; waddrM = 0; reg_wrM = 1; waddrW = 0; reg_wrW = 1;
    step(NoSt, 2'b01, 2'b01, 0, 0, 0);

    // Load-use
    mem_rdE = 1; waddrE = 7; raddr2D = 7; rs2_usedD = 1;
    step(St, 2'b01, 2'b01, 0, 0, 0);
    mem_rdE = 1; waddrE = 7; raddr2D = 7; rs2_usedD = 0;
    step(NoSt, 2'b01, 2'b01, 0, 0, 0);

    // MDU RAW on x9: issue at t, done at t+4, released at t+5
    mdu_startE = 1; waddrE = 9; raddr1D = 9; rs1_usedD = 1;
    step(St, 2'b01, 2'b01, 32'h1 << 9, 1, 0);
    for (int i = 0; i < 3; i++) begin
      raddr1D = 9; rs1_usedD = 1;
      step(St, 2'b01, 2'b01, 32'h1 << 9, 1, 0);
    end
    mdu_doneW = 1; waddrW = 9; reg_wrW = 1; raddr1D = 9; rs1_usedD = 1;
    step(St, 2'b01, 2'b01, 0, 0, 0);
    raddr1D = 9; rs1_usedD = 1;
    step(NoSt, 2'b01, 2'b01, 0, 0, 0);

    // Depth and WAW
    mdu_startE = 1; waddrE = 3;
    step(NoSt, 2'b01, 2'b01, B3, 1, 0);
    mdu_startE = 1; waddrE = 4; mdu_opD = 1;
    step(St, 2'b01, 2'b01, B3 | B4, 2, 0);
    mdu_opD = 1;
    step(St, 2'b01, 2'b01, B3 | B4, 2, 0);
    reg_wrD = 1; waddrD = 3;
    step(St, 2'b01, 2'b01, B3 | B4, 2, 0);
    reg_wrD = 1; waddrD = 5;
    step(NoSt, 2'b01, 2'b01, B3 | B4, 2, 0);
    mdu_doneW = 1; waddrW = 3; mdu_opD = 1;
    step(St, 2'b01, 2'b01, B4, 1, 0);
    mdu_opD = 1;
    step(NoSt, 2'b01, 2'b01, B4, 1, 0);

    // Redirect beats load-use stall
    br_taken = 1; mem_rdE = 1; waddrE = 8; raddr1D = 8; rs1_usedD = 1;
    step(Br, 2'b01, 2'b01, B4, 1, 0);

    // Clear beats increment
    cnt_clr = 1; mem_rdE = 1; waddrE = 8; raddr1D = 8; rs1_usedD = 1;
    step(St, 2'b01, 2'b01, B4, 1, 0);

    // Errors
    mdu_doneW = 1; waddrW = 4;
    step(NoSt, 2'b01, 2'b01, 0, 0, 0);
    mdu_doneW = 1; waddrW = 10;
    step(NoSt, 2'b01, 2'b01, 0, 0, 1);
    step(NoSt, 2'b01, 2'b01, 0, 0, 1);
    mdu_startE = 1; waddrE = 11;
    step(NoSt, 2'b01, 2'b01, 32'h1 << 11, 1, 1);
    mdu_startE = 1; waddrE = 12; br_taken = 1;
    step(Br, 2'b01, 2'b01, (32'h1 << 11) | (32'h1 << 12), 2, 1);

    // Asynchronous reset mid-flight, checked before any clock edge
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy_vec), 64'd0);
    chk("arst_cnt", 64'(mdu_cnt), 64'd0);
    chk("arst_err", 64'(sb_err), 64'd0);
    chk("arst_sc", 64'(stall_cnt), 64'd0);
    chk("arst_fc", 64'(flush_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_sc = '0;
    exp_fc = '0;
    step(NoSt, 2'b01, 2'b01, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor hazard unit for the 5-stage RV32IM pipeline. It keeps EX-stage operand forwarding (M over W priority) and load-use stalling, both now qualified for x0 and operand use. It adds a registered scoreboard of destination registers pending on the multi-cycle M-extension unit (MDU), with RAW, WAW and outstanding-depth stalls, plus saturating stall and flush event counters. It sits beside the pipeline registers, driving their stall and flush enables and the EX operand mux selects.

## Interface
- RAW, 5: register address width; NREGS = 2**RAW.
- MDU_DEPTH, 2: maximum MDU ops in flight, 1..7.
- CNT_W, 16: width of each event counter.

- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- raddr1D, raddr2D  in  RAW  D-stage source addresses.
- rs1_usedD, rs2_usedD  in  1  D instruction actually reads that source.
- waddrD  in  RAW  D-stage destination.
- reg_wrD  in  1  D instruction writes waddrD.
- mdu_opD  in  1  D instruction is an MDU op.
- raddr1E, raddr2E, waddrE  in  RAW  E-stage addresses.
- mem_rdE  in  1  E instruction is a load.
- mdu_startE  in  1  valid MDU op in E this cycle; it is issued.
- waddrM / reg_wrM  in  RAW / 1  M-stage destination and write enable.
- waddrW / reg_wrW  in  RAW / 1  W-stage destination and write enable.
- mdu_doneW  in  1  MDU result written back at W this cycle to waddrW.
- br_taken  in  1  branch or jump redirect resolved in E.
- cnt_clr  in  1  synchronous clear of both counters.
- StallF, StallD  out  1  hold the PC and the D register.
- FlushD, FlushE  out  1  bubble the D and E registers.
- forwardAE, forwardBE  out  2  operand select: 00 M result, 10 W result, 01 register file.
- busy_vec  out  NREGS  scoreboard bits; bit 0 is always 0.
- mdu_cnt  out  3  MDU ops outstanding.
- sb_err  out  1  sticky protocol error.
- stall_cnt, flush_cnt  out  CNT_W  event counters.

## Operation
**Forwarding** (combinational, per operand; shown for rs1):
- Select 00 if raddr1E != 0, reg_wrM = 1 and raddr1E == waddrM.
- Otherwise select 10 if raddr1E != 0, reg_wrW = 1 and raddr1E == waddrW.
- Otherwise select 01.

**Stall terms** (combinational):
- rawD: for each used source with a nonzero address, a hit on busy_vec, or on waddrE when mdu_startE = 1 and waddrE != 0.
- luD (load-use): mem_rdE = 1 and a used nonzero source equals waddrE.
- wawD: reg_wrD = 1, waddrD != 0, and waddrD is busy or equals waddrE of an issuing MDU op.
- fullD: mdu_opD = 1 and mdu_cnt + mdu_startE >= MDU_DEPTH.
- stall = rawD | luD | wawD | fullD.

**Output priority:**
- br_taken = 1: FlushD = 1, FlushE = 1, StallF = 0, StallD = 0. Redirect beats stall.
- Else stall = 1: StallF = 1, StallD = 1, FlushE = 1, FlushD = 0.
- Else all four are 0.

**Scoreboard** (registered):
- Set bit waddrE on mdu_startE when waddrE != 0.
- Clear bit waddrW on mdu_doneW.
- Set and clear of the same index in one cycle: set wins.
- mdu_cnt += mdu_startE, -= mdu_doneW.
- sb_err is set and held until reset by any of:
  - mdu_doneW with mdu_cnt = 0 (the count stays 0);
  - mdu_doneW to a clear bit;
  - mdu_startE with mdu_cnt = MDU_DEPTH (the count saturates).

**Counters:**
- stall_cnt increments each cycle the stall-output branch is taken.
- flush_cnt increments each cycle br_taken = 1.
- Both saturate at all-ones.
- cnt_clr has priority over increment.

## Timing
- Forwarding, Stall and Flush outputs are combinational, valid in the same cycle as their inputs.
- busy_vec, mdu_cnt, sb_err and the counters update on the rising clk edge.
- A clear by mdu_doneW in cycle t releases a RAW/WAW stall from cycle t+1. There is no same-cycle bypass, because the register file is written at the t edge.
- A set by mdu_startE in cycle t is covered in cycle t by the E-stage terms, and from t+1 by busy_vec.
- rst asserted: busy_vec = 0, mdu_cnt = 0, sb_err = 0, stall_cnt = 0, flush_cnt = 0. This takes effect immediately and asynchronously, including mid-operation with MDU ops in flight.
- Combinational outputs during reset follow the input equations using the reset state.
- br_taken never kills an issued MDU op. The upstream pipeline deasserts mdu_startE for flushed E slots.

## Test plan
- **Forwarding:** x5 written at M and W, E reads x5 -> forwardAE = 00. Only W writes x5 -> 10. raddr1E = 0 with M writing x0 -> 01.
- **Load-use:** load x7 in E, D add reads x7 with rs2_usedD = 1 -> StallF = StallD = FlushE = 1 for 1 cycle, stall_cnt = 1. Same case with rs2_usedD = 0 -> no stall.
- **MDU RAW:** mul x9 issues at t. D reads x9 -> stalled at t and onward. mdu_doneW for x9 at t+4 -> stall drops at t+5, busy_vec[9] = 0, mdu_cnt = 0.
- **Depth and WAW:** MDU_DEPTH = 2. Two divs to x3 and x4 in flight, third MDU op in D -> stalled until one completes. D writing x3 while x3 is busy -> stalled.
- **Priority:** br_taken together with load-use -> FlushD = FlushE = 1, StallF = 0, flush_cnt increments, stall_cnt does not.
- **Errors and reset:** mdu_doneW with mdu_cnt = 0 -> sb_err = 1 and held. rst asserted mid-flight with mdu_cnt = 2 -> all state 0 without waiting for a clk edge.
